// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, default bit timing and the RX FIFO entry format.
package uart_pkg;

  localparam int UART_DATA_W          = 8;
  localparam int CLKS_PER_BIT         = 20;
  localparam int TIMEOUT_CLKS_DEFAULT = 40 * CLKS_PER_BIT;

  typedef struct packed {
    logic                   err;
    logic [UART_DATA_W-1:0] data;
  } uart_rx_entry_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// Simple dual-port register array: synchronous write, asynchronous read.
// Contents are not reset; the owning FIFO tracks which entries are valid.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int DATA_W = $bits(uart_rx_entry_t)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side FWFT byte FIFO with error tags, fill level, full and sticky overrun.
// Optional idle timeout is built only when UART_RX_FIFO_TIMEOUT_EN is defined.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int ADDR_W       = $clog2(DEPTH),
  parameter int TIMEOUT_CLKS = TIMEOUT_CLKS_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [UART_DATA_W-1:0] rx_data,
  input  logic                   rx_valid,
  input  logic                   rx_err,
  output logic [UART_DATA_W-1:0] out_data,
  output logic                   out_err,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ADDR_W:0]        count,
  output logic                   full,
  output logic                   overrun,
  input  logic                   overrun_clr,
  output logic                   rx_timeout
);

  localparam int CW = ADDR_W + 1;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (TIMEOUT_CLKS < 1)) begin : g_bad_params
    $error("uart_rx_fifo: DEPTH must be a power of two >= 2 and TIMEOUT_CLKS >= 1");
  end

  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              r_full;
  logic              r_out_valid;
  logic              r_overrun;

  logic              w_wr;
  logic              w_rd;
  logic              w_accept;
  logic              w_drop;
  logic [CW-1:0]     w_count_nxt;
  uart_rx_entry_t    w_wr_entry;
  uart_rx_entry_t    w_rd_entry;

  uart_fifo_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W ($bits(uart_rx_entry_t))
  ) u_mem (
    .clk   (clk),
    .we    (w_accept),
    .waddr (r_wr_ptr),
    .wdata (w_wr_entry),
    .raddr (r_rd_ptr),
    .rdata (w_rd_entry)
  );

  // A write into a full FIFO is only accepted when the head leaves in the same cycle.
  always_comb begin
    w_wr            = rx_valid | rx_err;
    w_rd            = r_out_valid & out_ready;
    w_accept        = w_wr & (~r_full | w_rd);
    w_drop          = w_wr & r_full & ~w_rd;
    w_wr_entry.err  = rx_err;
    w_wr_entry.data = rx_data;
    if (w_accept && !w_rd) begin
      w_count_nxt = r_count + CW'(1);
    end else if (!w_accept && w_rd) begin
      w_count_nxt = r_count - CW'(1);
    end else begin
      w_count_nxt = r_count;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_full      <= 1'b0;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      end
      r_count     <= w_count_nxt;
      r_full      <= (w_count_nxt == CW'(DEPTH));
      r_out_valid <= (w_count_nxt != CW'(0));
      r_overrun   <= w_drop | (r_overrun & ~overrun_clr);
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_valid ? w_rd_entry.data : 8'h00;
  assign out_err   = r_out_valid ? w_rd_entry.err  : 1'b0;
  assign count     = r_count;
  assign full      = r_full;
  assign overrun   = r_overrun;

`ifdef UART_RX_FIFO_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);

  logic [TW-1:0] r_idle;
  logic [TW-1:0] w_idle_nxt;
  logic          r_timeout;

  // Idle time since the last FIFO activity, saturating at the threshold.
  always_comb begin
    if (w_wr || w_rd) begin
      w_idle_nxt = TW'(0);
    end else if ((r_count != CW'(0)) && (r_idle != TW'(TIMEOUT_CLKS))) begin
      w_idle_nxt = r_idle + TW'(1);
    end else begin
      w_idle_nxt = r_idle;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_idle    <= TW'(0);
      r_timeout <= 1'b0;
    end else begin
      r_idle    <= w_idle_nxt;
      r_timeout <= (w_idle_nxt == TW'(TIMEOUT_CLKS)) && (w_count_nxt != CW'(0));
    end
  end

  assign rx_timeout = r_timeout;
`else
  assign rx_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: vector table, directed corner sequences and
// randomized traffic against a queue-based reference model.
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;
  localparam int TMO   = 800;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_err = 1'b0;
  logic [7:0] out_data;
  logic       out_err;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [4:0] count;
  logic       full;
  logic       overrun;
  logic       overrun_clr = 1'b0;
  logic       rx_timeout;

  uart_rx_fifo #(.DEPTH(DEPTH), .TIMEOUT_CLKS(TMO)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_err      (rx_err),
    .out_data    (out_data),
    .out_err     (out_err),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .count       (count),
    .full        (full),
    .overrun     (overrun),
    .overrun_clr (overrun_clr),
    .rx_timeout  (rx_timeout)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [8:0] q[$];
  bit         m_ov = 1'b0;
  int         m_idle = 0;

  typedef struct {
    bit         v;
    bit         e;
    logic [7:0] d;
    bit         rdy;
    bit         clr;
    bit         ev;
    logic [7:0] ed;
    bit         ee;
    int         ecnt;
    bit         efull;
    bit         eov;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, advance the reference model at the edge, sample 1 ns later.
  task automatic cycle(input bit v, input bit e, input logic [7:0] d,
                       input bit rdy, input bit clr, input bit rst);
    int sz;
    bit rd, wrv, acc;
    rx_valid = v; rx_err = e; rx_data = d; out_ready = rdy; overrun_clr = clr; reset_n = !rst;
    @(posedge clk);
    sz  = q.size();
    wrv = v | e;
    if (rst) begin
      q.delete();
      m_ov   = 1'b0;
      m_idle = 0;
    end else begin
      rd  = (sz > 0) && rdy;
      acc = wrv && ((sz < DEPTH) || rd);
      if (wrv || rd) m_idle = 0;
      else if ((sz > 0) && (m_idle < TMO)) m_idle++;
      if (rd) void'(q.pop_front());
      if (acc) q.push_back({e, d});
      if (wrv && !acc) m_ov = 1'b1;
      else if (clr) m_ov = 1'b0;
    end
    #1;
  endtask

  task automatic idle_cycle();
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_model(input string tag);
    bit exp_to;
`ifdef UART_RX_FIFO_TIMEOUT_EN
    exp_to = (m_idle == TMO) && (q.size() > 0);
`else
    exp_to = 1'b0;
`endif
    chk({tag, ".valid"},   int'(out_valid), int'(q.size() > 0));
    chk({tag, ".data"},    int'(out_data),  (q.size() > 0) ? int'(q[0][7:0]) : 0);
    chk({tag, ".err"},     int'(out_err),   (q.size() > 0) ? int'(q[0][8]) : 0);
    chk({tag, ".count"},   int'(count),     q.size());
    chk({tag, ".full"},    int'(full),      int'(q.size() == DEPTH));
    chk({tag, ".overrun"}, int'(overrun),   int'(m_ov));
    chk({tag, ".timeout"}, int'(rx_timeout), int'(exp_to));
  endtask

  initial begin
    tbl[0]  = '{1, 0, 8'hA5, 0, 0,  1, 8'hA5, 0, 1, 0, 0};
    tbl[1]  = '{0, 0, 8'h00, 1, 0,  0, 8'h00, 0, 0, 0, 0};
    tbl[2]  = '{0, 1, 8'h3C, 0, 0,  1, 8'h3C, 1, 1, 0, 0};
    tbl[3]  = '{1, 0, 8'h41, 0, 0,  1, 8'h3C, 1, 2, 0, 0};
    tbl[4]  = '{1, 1, 8'h55, 0, 0,  1, 8'h3C, 1, 3, 0, 0};
    tbl[5]  = '{0, 0, 8'h00, 1, 0,  1, 8'h41, 0, 2, 0, 0};
    tbl[6]  = '{0, 0, 8'h00, 1, 0,  1, 8'h55, 1, 1, 0, 0};
    tbl[7]  = '{0, 0, 8'h00, 1, 0,  0, 8'h00, 0, 0, 0, 0};
    tbl[8]  = '{0, 0, 8'h00, 1, 0,  0, 8'h00, 0, 0, 0, 0};
    tbl[9]  = '{1, 0, 8'h12, 1, 0,  1, 8'h12, 0, 1, 0, 0};
    tbl[10] = '{1, 0, 8'h34, 1, 0,  1, 8'h34, 0, 1, 0, 0};
    tbl[11] = '{0, 0, 8'h00, 0, 1,  1, 8'h34, 0, 1, 0, 0};
    tbl[12] = '{0, 0, 8'h00, 1, 0,  0, 8'h00, 0, 0, 0, 0};

    // reset state
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("rst.valid", int'(out_valid), 0);
    chk("rst.data", int'(out_data), 0);
    chk("rst.err", int'(out_err), 0);
    chk("rst.count", int'(count), 0);
    chk("rst.full", int'(full), 0);
    chk("rst.overrun", int'(overrun), 0);
    chk("rst.timeout", int'(rx_timeout), 0);

    // basic FWFT, error tags, empty-read and simultaneous read/write
    foreach (tbl[i]) begin
      cycle(tbl[i].v, tbl[i].e, tbl[i].d, tbl[i].rdy, tbl[i].clr, 1'b0);
      chk($sformatf("tbl%0d.valid", i), int'(out_valid), int'(tbl[i].ev));
      chk($sformatf("tbl%0d.data", i), int'(out_data), int'(tbl[i].ed));
      chk($sformatf("tbl%0d.err", i), int'(out_err), int'(tbl[i].ee));
      chk($sformatf("tbl%0d.count", i), int'(count), tbl[i].ecnt);
      chk($sformatf("tbl%0d.full", i), int'(full), int'(tbl[i].efull));
      chk($sformatf("tbl%0d.overrun", i), int'(overrun), int'(tbl[i].eov));
    end

    // fill to 17 bytes: last one dropped
    for (int i = 0; i <= 16; i++) cycle(1'b1, 1'b0, 8'(i), 1'b0, 1'b0, 1'b0);
    chk("fill.count", int'(count), 16);
    chk("fill.full", int'(full), 1);
    chk("fill.overrun", int'(overrun), 1);
    chk("fill.head", int'(out_data), 8'h00);
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("ovclr.overrun", int'(overrun), 0);
    chk("ovclr.count", int'(count), 16);
    // full with simultaneous read and write
    cycle(1'b1, 1'b0, 8'hEE, 1'b1, 1'b0, 1'b0);
    chk("fullrw.count", int'(count), 16);
    chk("fullrw.full", int'(full), 1);
    chk("fullrw.overrun", int'(overrun), 0);
    for (int i = 1; i <= 16; i++) begin
      chk($sformatf("drain%0d.data", i), int'(out_data), (i == 16) ? 8'hEE : i);
      chk($sformatf("drain%0d.valid", i), int'(out_valid), 1);
      cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    chk("drain.count", int'(count), 0);
    chk("drain.valid", int'(out_valid), 0);

    // pointer wrap: 20 more bytes through in batches
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 10; i++) begin
        cycle(1'b1, 1'b0, 8'(8'h80 + b * 10 + i), 1'b0, 1'b0, 1'b0);
        check_model("wrapw");
      end
      for (int i = 0; i < 10; i++) begin
        chk("wrap.data", int'(out_data), 8'h80 + b * 10 + i);
        cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check_model("wrapr");
      end
    end

    // reset mid-operation
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0);
    chk("midrst.pre_count", int'(count), 5);
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("midrst.count", int'(count), 0);
    chk("midrst.valid", int'(out_valid), 0);
    chk("midrst.full", int'(full), 0);
    chk("midrst.overrun", int'(overrun), 0);
    cycle(1'b1, 1'b0, 8'h77, 1'b0, 1'b0, 1'b0);
    chk("midrst.head", int'(out_data), 8'h77);
    chk("midrst.count1", int'(count), 1);
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    check_model("midrst.empty");

    // idle timeout: one byte held for exactly TMO cycles
    cycle(1'b1, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i < TMO; i++) idle_cycle();
    chk("tmo.before", int'(rx_timeout), 0);
    idle_cycle();
`ifdef UART_RX_FIFO_TIMEOUT_EN
    chk("tmo.at", int'(rx_timeout), 1);
`else
    chk("tmo.at", int'(rx_timeout), 0);
`endif
    check_model("tmo.at");
    idle_cycle();
    check_model("tmo.hold");
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("tmo.after_rd", int'(rx_timeout), 0);
    check_model("tmo.after_rd");

    // randomized traffic with changing consumer pressure
    for (int i = 0; i < 3000; i++) begin
      int rdy_pct;
      rdy_pct = (i < 1000) ? 15 : ((i < 2000) ? 45 : 80);
      cycle($urandom_range(99) < 40, $urandom_range(99) < 10, 8'($urandom),
            $urandom_range(99) < rdy_pct, $urandom_range(99) < 5,
            $urandom_range(999) < 3);
      check_model("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive-side byte buffer that sits directly downstream of the UART receiver.
- Captures each received byte and its framing-error flag from the receiver's single-cycle strobes into a circular FIFO.
- Presents the bytes to the consumer on a first-word-fall-through valid/ready interface.
- Tracks fill level, full/empty and a sticky overrun flag, so bytes are never silently lost when the consumer stalls.

Parameters:
- DEPTH, 16: FIFO entries; power of two, minimum 2.
- ADDR_W, $clog2(DEPTH): pointer width; derived, do not override.
- TIMEOUT_CLKS, 800: idle-timeout threshold in clk cycles. Used only with UART_RX_FIFO_TIMEOUT_EN; default is 40 bit-times at 20 clks/bit.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- rx_data  in  8  byte from receiver; sampled only when rx_valid or rx_err is high.
- rx_valid  in  1  one-cycle strobe: good byte on rx_data.
- rx_err  in  1  one-cycle strobe: framing error, byte on rx_data is suspect.
- out_data  out  8  head-entry byte.
- out_err  out  1  head-entry error tag.
- out_valid  out  1  FIFO non-empty; head entry is presented.
- out_ready  in  1  consumer accepts head when out_valid and out_ready are both high.
- count  out  ADDR_W+1  entries currently stored, 0..DEPTH.
- full  out  1  count == DEPTH.
- overrun  out  1  sticky: a write was dropped because the FIFO was full.
- overrun_clr  in  1  one-cycle clear of overrun.
- rx_timeout  out  1  idle timeout (see Optional Feature).

Behaviour:
- Reset (reset_n low at a clk edge): wr_ptr=0, rd_ptr=0, count=0; out_valid=0, full=0, overrun=0, rx_timeout=0; out_data=0 and out_err=0.
  - Storage contents are don't-care.
  - Reset mid-operation discards all stored entries immediately.
- Write event: wr = rx_valid | rx_err.
  - Stored entry is {rx_err, rx_data}, 9 bits.
  - rx_valid and rx_err together produce one write with err=1.
- Read event: rd = out_valid & out_ready.
  - rd_ptr advances on that edge; the next entry appears the following cycle.
- FWFT output:
  - out_data and out_err always reflect mem[rd_ptr] while out_valid=1, and are 0 when empty.
  - Write into an empty FIFO: out_valid rises 1 cycle after the write strobe.
- Pointers are ADDR_W bits and wrap modulo DEPTH. count is tracked explicitly.
- Count update per cycle:
  - wr only, accepted: +1.
  - rd only: -1.
  - wr and rd same cycle: unchanged, both performed.
- Full boundary:
  - wr while full with no rd: data dropped, pointers unchanged, overrun set next edge.
  - wr while full with rd in the same cycle: accepted, no overrun.
- Empty boundary:
  - rd cannot occur (out_valid=0); out_ready is ignored.
- Overrun flag:
  - Set has priority over overrun_clr in the same cycle.
  - Otherwise overrun_clr clears it on the next edge.
- full and out_valid are registered and derived from the next-state count, so there is no combinational path from rx_* to out_*.
- Upstream contract: strobes are single-cycle, at most one byte per cycle. A strobe held for k cycles is k writes.

Optional Feature:
- Macro UART_RX_FIFO_TIMEOUT_EN.
- Defined:
  - An idle counter resets to 0 on any wr, any rd, or reset. Otherwise it increments while count>0, saturating at TIMEOUT_CLKS.
  - rx_timeout=1 while counter == TIMEOUT_CLKS and count>0. It is used by firmware to flush partial messages.
  - rx_timeout drops the cycle after the next wr or rd.
- Undefined:
  - No counter logic is instantiated; rx_timeout is tied to 0.
  - The port remains present so instantiations are unchanged.

Decomposition:
- Shared package uart_pkg holds:
  - UART_DATA_W=8.
  - Default CLKS_PER_BIT=20.
  - Entry typedef uart_rx_entry_t as a packed {err, data[7:0]}.
  - Localparam for the default TIMEOUT_CLKS.
- One sub-module: uart_fifo_mem, a simple dual-port register array.
  - Write port: clk, we, waddr, wdata.
  - Read port: asynchronous read.
  - Reusable by the planned TX FIFO.
- Pointer, count, flag and timeout logic stay in uart_rx_fifo.

Test Plan:
- Basic FWFT: after reset, pulse rx_valid with rx_data=8'hA5, out_ready=0.
  - out_valid=1, out_data=8'hA5, out_err=0, count=1 one cycle later.
  - Then out_ready=1 for one cycle → count=0, out_valid=0.
- Error tag: pulse rx_err with rx_data=8'h3C, then rx_valid with 8'h41.
  - Reads return {err=1, 8'h3C} then {err=0, 8'h41}.
  - A combined rx_valid+rx_err strobe with 8'h55 is one entry, err=1.
- Fill, overrun and wrap: DEPTH=16, write 8'h00..8'h10 (17 bytes) with out_ready=0.
  - full=1, count=16, overrun=1; bytes 8'h00..8'h0F read back in order.
  - Pulse overrun_clr → overrun=0.
  - Write and read 20 more bytes → pointer wrap with data intact.
- Full plus simultaneous read/write: while full, strobe rx_valid with 8'hEE and out_ready=1 in the same cycle.
  - count stays 16, overrun stays 0, 8'hEE is the last entry read.
- Reset mid-operation: with count=5, drive reset_n=0 for one edge.
  - count=0, out_valid=0, full=0, overrun=0.
  - Next write of 8'h77 reads back as the first entry.
- Timeout (with UART_RX_FIFO_TIMEOUT_EN): write 1 byte, hold out_ready=0.
  - rx_timeout=1 exactly 800 cycles later.
  - A read clears it next cycle; with the macro undefined, rx_timeout stays 0 throughout.
